radix_4_ntt_intt_pe_pipe: RTL and testbench

Pipelined, parametrised radix-4 butterfly processing element for the NTT/INTT datapath.
- Mode is selected per beat: forward uses Cooley-Tukey (DIT, twiddles applied first); inverse uses Gentleman-Sande (DIF, twiddles applied last).
- Fixed latency in both modes, one beat per cycle, valid/ready backpressure.
- Sits between the coefficient-memory read stage and the write-back stage of the NTT engine.

---
 rtl/radix_4_ntt_intt_pe_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_radix_4_ntt_intt_pe_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix_4_ntt_intt_pe_pipe.sv
//----------------------------------------------------------------------------
// radix_4_ntt_intt_pe_pipe : pipelined radix-4 NTT (CT/DIT) / INTT (GS/DIF)
// butterfly with fixed latency 3*MUL_STAGES+2 and valid/ready backpressure.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

// Modular multiplier: full 2N-bit product reduced mod Q over MUL_STAGES cycles.
module radix_4_ntt_intt_pe_pipe_mulmod #(
    parameter int N          = 17,
    parameter int Q          = 65537,
    parameter int MUL_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] z
);
    localparam logic [2*N-1:0] Q_W = (2*N)'(Q);

    logic [2*N-1:0] prod;
    assign prod = {{N{1'b0}}, x} * {{N{1'b0}}, y};

    generate
        if (MUL_STAGES == 1) begin : g_single
            logic [N-1:0] z_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    z_q <= '0;
                end else if (en && in_valid) begin
                    z_q <= N'(prod % Q_W);
                end
            end
            assign z = z_q;
        end else begin : g_multi
            logic [MUL_STAGES-2:0] vld;
            logic [2*N-1:0]        prod_q;
            logic [N-1:0]          red_q [1:MUL_STAGES-1];

            // Stage 0 registers the raw product, stage 1 reduces, the rest delay.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld    <= '0;
                    prod_q <= '0;
                    for (int k = 1; k < MUL_STAGES; k++) red_q[k] <= '0;
                end else if (en) begin
                    vld[0] <= in_valid;
                    for (int k = 1; k < MUL_STAGES - 1; k++) vld[k] <= vld[k-1];
                    if (in_valid) prod_q <= prod;
                    if (vld[0]) red_q[1] <= N'(prod_q % Q_W);
                    for (int k = 2; k < MUL_STAGES; k++) begin
                        if (vld[k-1]) red_q[k] <= red_q[k-1];
                    end
                end
            end
            assign z = red_q[MUL_STAGES-1];
        end
    endgenerate
endmodule

module radix_4_ntt_intt_pe_pipe #(
    parameter int N          = 17,
    parameter int Q          = 65537,
    parameter int MUL_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] a2,
    input  logic [N-1:0] a3,
    input  logic [N-1:0] tf1,
    input  logic [N-1:0] tf2,
    input  logic [N-1:0] tf3,
    input  logic [N-1:0] tf_j,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] b0,
    output logic [N-1:0] b1,
    output logic [N-1:0] b2,
    output logic [N-1:0] b3,
    output logic         inv_out
);
    localparam int          M     = MUL_STAGES;
    localparam int          L     = 3 * MUL_STAGES + 2;
    localparam int          W_LEN = 2 * MUL_STAGES + 2;
    localparam logic [N:0]  Q_EXT = (N+1)'(Q);
    localparam logic [N-1:0] ONE  = N'(1);

    function automatic logic [N-1:0] add_mod(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_EXT) s = s - Q_EXT;
        return N'(s);
    endfunction

    function automatic logic [N-1:0] sub_mod(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] d;
        d = {1'b0, x} + Q_EXT - {1'b0, y};
        if (d >= Q_EXT) d = d - Q_EXT;
        return N'(d);
    endfunction

    logic stall, en, accept;
    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // Sideband travelling with each beat; only valid stages update the payload.
    logic [L-1:0] sc_valid;
    logic [L-1:0] sc_inv;
    logic [N-1:0] sc_w1 [W_LEN];
    logic [N-1:0] sc_w2 [W_LEN];
    logic [N-1:0] sc_w3 [W_LEN];
    logic [N-1:0] sc_j  [M+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_valid <= '0;
            sc_inv   <= '0;
            for (int k = 0; k < W_LEN; k++) begin
                sc_w1[k] <= '0;
                sc_w2[k] <= '0;
                sc_w3[k] <= '0;
            end
            for (int k = 0; k <= M; k++) sc_j[k] <= '0;
        end else if (en) begin
            sc_valid[0] <= accept;
            if (accept) begin
                sc_inv[0] <= inv;
                sc_w1[0]  <= tf1;
                sc_w2[0]  <= tf2;
                sc_w3[0]  <= tf3;
                sc_j[0]   <= tf_j;
            end
            for (int k = 1; k < L; k++) begin
                sc_valid[k] <= sc_valid[k-1];
                if (sc_valid[k-1]) sc_inv[k] <= sc_inv[k-1];
            end
            for (int k = 1; k < W_LEN; k++) begin
                if (sc_valid[k-1]) begin
                    sc_w1[k] <= sc_w1[k-1];
                    sc_w2[k] <= sc_w2[k-1];
                    sc_w3[k] <= sc_w3[k-1];
                end
            end
            for (int k = 1; k <= M; k++) begin
                if (sc_valid[k-1]) sc_j[k] <= sc_j[k-1];
            end
        end
    end

    logic [N-1:0] in_a  [4];
    logic [N-1:0] in_w  [4];
    logic [N-1:0] out_w [4];
    logic [N-1:0] in_y  [4];
    logic [N-1:0] j_y   [4];
    logic [N-1:0] out_y [4];
    logic [N-1:0] m     [4];
    logic [N-1:0] t     [4];
    logic [N-1:0] u     [4];
    logic [N-1:0] s     [4];
    logic [N-1:0] r     [4];

    assign in_a[0]  = a0;
    assign in_a[1]  = a1;
    assign in_a[2]  = a2;
    assign in_a[3]  = a3;
    assign in_w[0]  = ONE;
    assign in_w[1]  = tf1;
    assign in_w[2]  = tf2;
    assign in_w[3]  = tf3;
    assign out_w[0] = ONE;
    assign out_w[1] = sc_w1[2*M+1];
    assign out_w[2] = sc_w2[2*M+1];
    assign out_w[3] = sc_w3[2*M+1];

    // Multiplying by one turns a multiplier slot into a pure delay of equal latency.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign in_y[i]  = inv ? ONE : in_w[i];
            assign j_y[i]   = (i == 3) ? sc_j[M] : ONE;
            assign out_y[i] = sc_inv[2*M+1] ? out_w[i] : ONE;

            radix_4_ntt_intt_pe_pipe_mulmod #(.N(N), .Q(Q), .MUL_STAGES(M)) u_in_mul (
                .clk(clk), .rst_n(rst_n), .en(en), .in_valid(accept),
                .x(in_a[i]), .y(in_y[i]), .z(m[i])
            );
            radix_4_ntt_intt_pe_pipe_mulmod #(.N(N), .Q(Q), .MUL_STAGES(M)) u_j_mul (
                .clk(clk), .rst_n(rst_n), .en(en), .in_valid(sc_valid[M]),
                .x(t[i]), .y(j_y[i]), .z(u[i])
            );
            radix_4_ntt_intt_pe_pipe_mulmod #(.N(N), .Q(Q), .MUL_STAGES(M)) u_out_mul (
                .clk(clk), .rst_n(rst_n), .en(en), .in_valid(sc_valid[2*M+1]),
                .x(s[i]), .y(out_y[i]), .z(r[i])
            );
        end
    endgenerate

    // Both add stages share one structure: forward feeds products, inverse raw inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) t[i] <= '0;
        end else if (en && sc_valid[M-1]) begin
            t[0] <= add_mod(m[0], m[2]);
            t[1] <= sub_mod(m[0], m[2]);
            t[2] <= add_mod(m[1], m[3]);
            t[3] <= sub_mod(m[1], m[3]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) s[i] <= '0;
        end else if (en && sc_valid[2*M]) begin
            s[0] <= add_mod(u[0], u[2]);
            s[1] <= add_mod(u[1], u[3]);
            s[2] <= sub_mod(u[0], u[2]);
            s[3] <= sub_mod(u[1], u[3]);
        end
    end

    assign b0        = r[0];
    assign b1        = r[1];
    assign b2        = r[2];
    assign b3        = r[3];
    assign out_valid = sc_valid[L-1];
    assign inv_out   = sc_inv[L-1];
endmodule

`default_nettype wire

// File: tb/tb_radix_4_ntt_intt_pe_pipe.sv
//----------------------------------------------------------------------------
// tb_radix_4_ntt_intt_pe_pipe : directed bench for the radix-4 butterfly PE
// at N=5, Q=17, MUL_STAGES=2.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_radix_4_ntt_intt_pe_pipe;
    localparam int N  = 5;
    localparam int Q  = 17;
    localparam int MS = 2;
    localparam int L  = 3 * MS + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         inv = 1'b0;
    logic         out_ready = 1'b1;
    logic [N-1:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;
    logic [N-1:0] tf1 = '0, tf2 = '0, tf3 = '0, tf_j = '0;
    logic         in_ready, out_valid, inv_out;
    logic [N-1:0] b0, b1, b2, b3;

    int           checks = 0;
    int           errors = 0;
    logic [20:0]  exp_q [$];
    int           acc_cnt = 0;
    int           out_cnt = 0;

    radix_4_ntt_intt_pe_pipe #(.N(N), .Q(Q), .MUL_STAGES(MS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inv(inv), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .tf1(tf1), .tf2(tf2), .tf3(tf3), .tf_j(tf_j),
        .out_valid(out_valid), .out_ready(out_ready),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .inv_out(inv_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed running required finished");
        $fatal(1, "timeout");
    end

    function automatic logic [20:0] pack(input int iv, input int r0, input int r1,
                                         input int r2, input int r3);
        return {1'(iv), 5'(r0), 5'(r1), 5'(r2), 5'(r3)};
    endfunction

    function automatic logic [20:0] model(input int iv, input int x0, input int x1,
                                          input int x2, input int x3, input int w1,
                                          input int w2, input int w3, input int j);
        int p1, p2, p3, t0, t1, t2, t3, r0, r1, r2, r3;
        if (iv == 0) begin
            p1 = x1 * w1 % Q;
            p2 = x2 * w2 % Q;
            p3 = x3 * w3 % Q;
            t0 = (x0 + p2) % Q;
            t1 = (x0 - p2 + Q) % Q;
            t2 = (p1 + p3) % Q;
            t3 = ((p1 - p3 + Q) % Q) * j % Q;
            r0 = (t0 + t2) % Q;
            r1 = (t1 + t3) % Q;
            r2 = (t0 - t2 + Q) % Q;
            r3 = (t1 - t3 + Q) % Q;
        end else begin
            t0 = (x0 + x2) % Q;
            t1 = (x0 - x2 + Q) % Q;
            t2 = (x1 + x3) % Q;
            t3 = ((x1 - x3 + Q) % Q) * j % Q;
            r0 = (t0 + t2) % Q;
            r1 = (t1 + t3) % Q * w1 % Q;
            r2 = (t0 - t2 + Q) % Q * w2 % Q;
            r3 = (t1 - t3 + Q) % Q * w3 % Q;
        end
        return pack(iv, r0, r1, r2, r3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic [20:0] e);
        logic [4:0] f0, f1, f2, f3;
        f0 = e[19:15];
        f1 = e[14:10];
        f2 = e[9:5];
        f3 = e[4:0];
        chk({tag, "_b0"}, 32'(b0), 32'(f0));
        chk({tag, "_b1"}, 32'(b1), 32'(f1));
        chk({tag, "_b2"}, 32'(b2), 32'(f2));
        chk({tag, "_b3"}, 32'(b3), 32'(f3));
        chk({tag, "_inv"}, 32'(inv_out), 32'(e[20]));
    endtask

    task automatic set_beat(input int iv, input int x0, input int x1, input int x2,
                            input int x3, input int w1, input int w2, input int w3,
                            input int j);
        inv  = 1'(iv);
        a0   = 5'(x0);
        a1   = 5'(x1);
        a2   = 5'(x2);
        a3   = 5'(x3);
        tf1  = 5'(w1);
        tf2  = 5'(w2);
        tf3  = 5'(w3);
        tf_j = 5'(j);
    endtask

    task automatic beat_k(input int k);
        set_beat(k % 2, (3*k+1) % Q, (3*k+6) % Q, (3*k+11) % Q, (3*k+16) % Q,
                 (2*k+7) % Q, (2*k+14) % Q, (2*k+21) % Q, (k % 2 == 1) ? 13 : 4);
    endtask

    // One clock: record accepted beats in the scoreboard, check consumed outputs.
    task automatic cycle();
        logic [20:0] e;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(int'(inv), int'(a0), int'(a1), int'(a2), int'(a3),
                                  int'(tf1), int'(tf2), int'(tf3), int'(tf_j)));
            acc_cnt++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk_b("stream", e);
            end
            out_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input string tag, input logic [20:0] e);
        int lat;
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(L));
        chk_b(tag, e);
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk_b({tag, "_hold"}, e);
    endtask

    initial begin
        int first_acc, first_out, last_out, nvalid, stall_seen, cnt;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk_b("rst", 21'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed single beats with hand-computed results
        set_beat(0, 1, 2, 3, 4, 1, 1, 1, 4);
        run_single("fwd", pack(0, 10, 7, 15, 6));
        set_beat(1, 10, 7, 15, 6, 1, 1, 1, 13);
        run_single("inv", pack(1, 4, 8, 12, 16));
        set_beat(0, 16, 16, 16, 16, 16, 16, 16, 4);
        run_single("bnd", pack(0, 2, 15, 15, 15));

        // Back-to-back stream of 20 beats alternating mode
        acc_cnt = 0; out_cnt = 0; first_acc = -1; first_out = -1; last_out = -1; nvalid = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (acc_cnt < 20) begin
                beat_k(acc_cnt);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready && first_acc < 0) first_acc = c;
            if (out_valid) begin
                if (first_out < 0) first_out = c;
                last_out = c;
                nvalid++;
            end
            cycle();
            if (acc_cnt == 20 && exp_q.size() == 0) break;
        end
        chk("stream_first_latency", 32'(first_out - first_acc), 32'(L));
        chk("stream_valid_count", 32'(nvalid), 32'd20);
        chk("stream_contiguous", 32'(last_out - first_out + 1), 32'd20);
        chk("stream_out_count", 32'(out_cnt), 32'd20);
        chk("stream_leftover", 32'(exp_q.size()), 32'd0);

        // Backpressure: out_ready low for three cycles while outputs are valid
        acc_cnt = 0; out_cnt = 0; stall_seen = 0;
        for (int c = 0; c < 80; c++) begin
            if (acc_cnt < 10) begin
                beat_k(acc_cnt + 3);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(c >= 9 && c < 12);
            #1;
            if (!out_ready && out_valid) begin
                stall_seen++;
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                if (exp_q.size() > 0) chk_b("bp_hold", exp_q[0]);
            end
            cycle();
            if (acc_cnt == 10 && exp_q.size() == 0) break;
        end
        out_ready = 1'b1;
        chk("bp_stall_cycles", 32'(stall_seen), 32'd3);
        chk("bp_out_count", 32'(out_cnt), 32'd10);
        chk("bp_leftover", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream discards in-flight beats
        acc_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            beat_k(c + 5);
            in_valid = 1'b1;
            #1;
            cycle();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk_b("rstmid", 21'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rstmid_release_valid", 32'(out_valid), 32'd0);
        set_beat(0, 1, 2, 3, 4, 1, 1, 1, 4);
        run_single("post_rst", pack(0, 10, 7, 15, 6));
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) cnt++;
            @(posedge clk);
            #1;
        end
        chk("post_rst_stale_beats", 32'(cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
